// File: rtl/rob_wb_arbiter.sv
// Writeback collector: per-channel result FIFOs feeding NUM_PORTS ROB completion ports.
// Mispredict/exception heads win over normal heads; normal heads share ports round-robin.
module rob_wb_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int NUM_PORTS   = 2,
    parameter int DEPTH       = 4,
    parameter int ROB_ENTRIES = 32,
    parameter int DATA_W      = 32,
    localparam int IDX_W      = $clog2(ROB_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic [NUM_CH-1:0]           ch_valid_i,
    output logic [NUM_CH-1:0]           ch_ready_o,
    input  logic [NUM_CH*IDX_W-1:0]     ch_idx_i,
    input  logic [NUM_CH*DATA_W-1:0]    ch_val_i,
    input  logic [NUM_CH-1:0]           ch_mispred_i,
    input  logic [NUM_CH-1:0]           ch_exc_i,
    output logic [NUM_PORTS-1:0]        wb_valid_o,
    output logic [NUM_PORTS*IDX_W-1:0]  wb_idx_o,
    output logic [NUM_PORTS*DATA_W-1:0] wb_val_o,
    output logic [NUM_PORTS-1:0]        wb_mispred_o,
    output logic [NUM_PORTS-1:0]        wb_exc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
        logic              mispred;
        logic              exc;
    } entry_t;

    entry_t           mem_q    [NUM_CH][DEPTH];
    entry_t           mem_d    [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [RR_W-1:0]  rr_q;
    logic [RR_W-1:0]  rr_d;

    entry_t            head       [NUM_CH];
    logic [NUM_CH-1:0] head_valid;
    logic [NUM_CH-1:0] head_pri;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    always_comb begin
        head_valid = '0;
        head_pri   = '0;
        ch_ready_o = '0;
        push       = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            head[c]       = mem_q[c][rd_ptr_q[c]];
            head_valid[c] = (cnt_q[c] != '0);
            head_pri[c]   = head_valid[c] & (head[c].mispred | head[c].exc);
            // Ready ignores a same-cycle pop so the channel sees no comb path from the arbiter.
            ch_ready_o[c] = (cnt_q[c] < CNT_W'(DEPTH)) & ~flush_i;
            push[c]       = ch_valid_i[c] & ch_ready_o[c];
        end
    end

    // Each port takes the first untaken head in (class A, then class B) x rotated channel order.
    always_comb begin
        logic [NUM_CH-1:0] taken;
        logic [RR_W-1:0]   ch;
        logic [RR_W-1:0]   sel;
        logic [RR_W-1:0]   last_b;
        logic              found;
        logic              any_b;

        taken        = '0;
        ch           = '0;
        sel          = '0;
        last_b       = '0;
        found        = 1'b0;
        any_b        = 1'b0;
        pop          = '0;
        wb_valid_o   = '0;
        wb_idx_o     = '0;
        wb_val_o     = '0;
        wb_mispred_o = '0;
        wb_exc_o     = '0;
        rr_d         = rr_q;

        if (flush_i) begin
            rr_d = '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                found = 1'b0;
                sel   = '0;
                for (int unsigned cls = 0; cls < 2; cls++) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        ch = RR_W'((32'(rr_q) + i) % NUM_CH);
                        if (!found && head_valid[ch] && !taken[ch] &&
                            (head_pri[ch] == (cls == 0))) begin
                            found = 1'b1;
                            sel   = ch;
                        end
                    end
                end
                if (found) begin
                    taken[sel]                     = 1'b1;
                    pop[sel]                       = 1'b1;
                    wb_valid_o[p]                  = 1'b1;
                    wb_idx_o[p*IDX_W +: IDX_W]     = head[sel].idx;
                    wb_val_o[p*DATA_W +: DATA_W]   = head[sel].val;
                    wb_mispred_o[p]                = head[sel].mispred;
                    wb_exc_o[p]                    = head[sel].exc;
                    if (!head_pri[sel]) begin
                        any_b  = 1'b1;
                        last_b = sel;
                    end
                end
            end
            if (any_b) begin
                rr_d = RR_W'((32'(last_b) + 1) % NUM_CH);
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (flush_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end else begin
                if (push[c]) begin
                    mem_d[c][wr_ptr_q[c]].idx     = ch_idx_i[c*IDX_W +: IDX_W];
                    mem_d[c][wr_ptr_q[c]].val     = ch_val_i[c*DATA_W +: DATA_W];
                    mem_d[c][wr_ptr_q[c]].mispred = ch_mispred_i[c];
                    mem_d[c][wr_ptr_q[c]].exc     = ch_exc_i[c];
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                    2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= '0;
                end
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= mem_d[c][d];
                end
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            rr_q <= rr_d;
        end
    end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model that ranks heads by (class, distance from rr pointer).
module tb_rob_wb_arbiter;

    localparam int NUM_CH      = 4;
    localparam int NUM_PORTS   = 2;
    localparam int DEPTH       = 4;
    localparam int ROB_ENTRIES = 32;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = $clog2(ROB_ENTRIES);
    localparam int VW          = NUM_PORTS * (1 + IDX_W + DATA_W + 2) + NUM_CH;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        flush_i = 1'b0;
    logic [NUM_CH-1:0]           ch_valid_i = '0;
    logic [NUM_CH-1:0]           ch_ready_o;
    logic [NUM_CH*IDX_W-1:0]     ch_idx_i = '0;
    logic [NUM_CH*DATA_W-1:0]    ch_val_i = '0;
    logic [NUM_CH-1:0]           ch_mispred_i = '0;
    logic [NUM_CH-1:0]           ch_exc_i = '0;
    logic [NUM_PORTS-1:0]        wb_valid_o;
    logic [NUM_PORTS*IDX_W-1:0]  wb_idx_o;
    logic [NUM_PORTS*DATA_W-1:0] wb_val_o;
    logic [NUM_PORTS-1:0]        wb_mispred_o;
    logic [NUM_PORTS-1:0]        wb_exc_o;

    always #5 clk = ~clk;

    rob_wb_arbiter #(
        .NUM_CH      (NUM_CH),
        .NUM_PORTS   (NUM_PORTS),
        .DEPTH       (DEPTH),
        .ROB_ENTRIES (ROB_ENTRIES),
        .DATA_W      (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .ch_valid_i   (ch_valid_i),
        .ch_ready_o   (ch_ready_o),
        .ch_idx_i     (ch_idx_i),
        .ch_val_i     (ch_val_i),
        .ch_mispred_i (ch_mispred_i),
        .ch_exc_i     (ch_exc_i),
        .wb_valid_o   (wb_valid_o),
        .wb_idx_o     (wb_idx_o),
        .wb_val_o     (wb_val_o),
        .wb_mispred_o (wb_mispred_o),
        .wb_exc_o     (wb_exc_o)
    );

    typedef struct {
        int unsigned idx;
        int unsigned val;
        bit          mis;
        bit          exc;
    } ent_t;

    ent_t        mq [NUM_CH][$];
    int unsigned mrr;
    int          gch [NUM_PORTS];
    int          ngr;

    logic [NUM_PORTS-1:0]        e_valid, e_mis, e_exc;
    logic [NUM_PORTS*IDX_W-1:0]  e_idx;
    logic [NUM_PORTS*DATA_W-1:0] e_val;
    logic [NUM_CH-1:0]           e_ready;
    logic [VW-1:0]               exp_vec;
    logic [VW-1:0]               obs_vec;

    assign obs_vec = {wb_valid_o, wb_idx_o, wb_val_o, wb_mispred_o, wb_exc_o, ch_ready_o};

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs for the current cycle: each port takes the lowest-ranked
    // remaining head, rank = distance from mrr, plus NUM_CH for normal results.
    task automatic model_eval();
        bit taken [NUM_CH];
        int best, best_key, key;
        e_valid = '0; e_mis = '0; e_exc = '0; e_idx = '0; e_val = '0; ngr = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            taken[c]   = 1'b0;
            e_ready[c] = (mq[c].size() < DEPTH) && !flush_i;
        end
        if (!flush_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                best = -1;
                best_key = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mq[c].size() > 0 && !taken[c]) begin
                        key = ((c - int'(mrr) + NUM_CH) % NUM_CH) +
                              ((mq[c][0].mis || mq[c][0].exc) ? 0 : NUM_CH);
                        if (best < 0 || key < best_key) begin
                            best = c;
                            best_key = key;
                        end
                    end
                end
                if (best >= 0) begin
                    taken[best] = 1'b1;
                    gch[p] = best;
                    ngr++;
                    e_valid[p] = 1'b1;
                    e_idx[p*IDX_W +: IDX_W]   = IDX_W'(mq[best][0].idx);
                    e_val[p*DATA_W +: DATA_W] = mq[best][0].val;
                    e_mis[p] = mq[best][0].mis;
                    e_exc[p] = mq[best][0].exc;
                end
            end
        end
        exp_vec = {e_valid, e_idx, e_val, e_mis, e_exc, e_ready};
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        mrr = 0;
    endtask

    task automatic model_commit();
        int   last_b;
        ent_t e;
        last_b = -1;
        if (!rst_n || flush_i) begin
            model_reset();
            return;
        end
        for (int p = 0; p < ngr; p++) begin
            if (!(mq[gch[p]][0].mis || mq[gch[p]][0].exc)) last_b = gch[p];
            void'(mq[gch[p]].pop_front());
        end
        if (last_b >= 0) mrr = (last_b + 1) % NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid_i[c] && e_ready[c]) begin
                e.idx = ch_idx_i[c*IDX_W +: IDX_W];
                e.val = ch_val_i[c*DATA_W +: DATA_W];
                e.mis = ch_mispred_i[c];
                e.exc = ch_exc_i[c];
                mq[c].push_back(e);
            end
        end
    endtask

    task automatic clr_in();
        flush_i = 1'b0; ch_valid_i = '0; ch_idx_i = '0; ch_val_i = '0;
        ch_mispred_i = '0; ch_exc_i = '0;
    endtask

    task automatic set_ch(input int c, input int unsigned idx, input int unsigned val,
                          input bit mis, input bit exc);
        ch_valid_i[c] = 1'b1;
        ch_idx_i[c*IDX_W +: IDX_W] = IDX_W'(idx);
        ch_val_i[c*DATA_W +: DATA_W] = val;
        ch_mispred_i[c] = mis;
        ch_exc_i[c] = exc;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            clr_in(); #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL reset_hold%0d: got %h expected %h", j, obs_vec, exp_vec); end
            model_commit(); @(negedge clk);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            clr_in();
            if (j == 0) set_ch(2, 5, 32'hDEAD, 0, 0);
            if (j == 2) begin set_ch(0, 10, 32'h100, 0, 0); set_ch(1, 11, 32'h101, 0, 0); set_ch(3, 13, 32'h103, 0, 0); end
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL single_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            if (j == 0) begin
                n_vec++;
                if (ch_ready_o !== 4'hF) begin n_err++; $display("FAIL ready_after_reset: got %h expected f", ch_ready_o); end
            end
            if (j == 1) begin
                n_vec++;
                if (wb_valid_o !== 2'b01 || wb_idx_o[4:0] !== 5'd5 || wb_val_o[31:0] !== 32'hDEAD) begin
                    n_err++; $display("FAIL single_result: got v=%b idx=%0d val=%h expected v=01 idx=5 val=dead", wb_valid_o, wb_idx_o[4:0], wb_val_o[31:0]);
                end
            end
            if (j == 3) begin
                n_vec++;
                if (wb_valid_o !== 2'b11 || wb_idx_o !== {5'd10, 5'd13}) begin
                    n_err++; $display("FAIL rr_after_single: got v=%b idx=%h expected v=11 idx=%h", wb_valid_o, wb_idx_o, {5'd10, 5'd13});
                end
            end
            model_commit(); @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_lo, exp_hi;
        clr_in(); flush_i = 1'b1; #1; model_eval(); model_commit(); @(negedge clk);
        clr_in();
        for (int c = 0; c < NUM_CH; c++) set_ch(c, c*4, 32'h1000 + c, 0, 0);
        #1; model_eval();
        n_vec++;
        if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rr_fill: got %h expected %h", obs_vec, exp_vec); end
        model_commit(); @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            clr_in();
            if (j == 0) for (int c = 0; c < NUM_CH; c++) set_ch(c, c*4 + 1, 32'h2000 + c, 0, 0);
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rr_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            if (j < 4) begin
                exp_lo = 5'((j % 2) * 8 + j / 2);
                exp_hi = 5'((j % 2) * 8 + 4 + j / 2);
                n_vec++;
                if (wb_valid_o !== 2'b11 || wb_idx_o !== {exp_hi, exp_lo}) begin
                    n_err++; $display("FAIL rr_grant%0d: got v=%b idx=%h expected v=11 idx=%h", j, wb_valid_o, wb_idx_o, {exp_hi, exp_lo});
                end
            end else begin
                n_vec++;
                if (wb_valid_o !== 2'b00 || ch_ready_o !== 4'hF) begin
                    n_err++; $display("FAIL rr_drained: got v=%b rdy=%h expected v=00 rdy=f", wb_valid_o, ch_ready_o);
                end
            end
            model_commit(); @(negedge clk);
        end
    endtask

    task automatic test_priority();
        clr_in(); flush_i = 1'b1; #1; model_eval(); model_commit(); @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            clr_in();
            if (j == 0) begin set_ch(0, 1, 32'hA0, 0, 0); set_ch(1, 2, 32'hA1, 0, 0); set_ch(3, 3, 32'hA3, 0, 1); end
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL prio_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            if (j == 1) begin
                n_vec++;
                if (wb_valid_o !== 2'b11 || wb_idx_o !== {5'd1, 5'd3} || wb_exc_o !== 2'b01) begin
                    n_err++; $display("FAIL prio_exc_first: got v=%b idx=%h exc=%b expected v=11 idx=%h exc=01", wb_valid_o, wb_idx_o, wb_exc_o, {5'd1, 5'd3});
                end
            end
            if (j == 2) begin
                n_vec++;
                if (wb_valid_o !== 2'b01 || wb_idx_o[4:0] !== 5'd2) begin
                    n_err++; $display("FAIL prio_next: got v=%b idx0=%0d expected v=01 idx0=2", wb_valid_o, wb_idx_o[4:0]);
                end
            end
            model_commit(); @(negedge clk);
        end
    endtask

    task automatic test_full_fifo();
        int unsigned vals [5];
        int unsigned got [$];
        for (int k = 0; k < 5; k++) vals[k] = $urandom;
        clr_in(); flush_i = 1'b1; #1; model_eval(); model_commit(); @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            clr_in();
            if (j < 5) begin
                set_ch(0, 1, $urandom, 1, 0);
                set_ch(2, 2, $urandom, 0, 1);
                set_ch(1, 16 + j, vals[j], 0, 0);
            end
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL full_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            if (j == 4) begin
                n_vec++;
                if (ch_ready_o[1] !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", ch_ready_o[1]); end
            end
            for (int p = 0; p < NUM_PORTS; p++)
                if (wb_valid_o[p] === 1'b1 && wb_idx_o[p*IDX_W +: IDX_W] >= 5'd16)
                    got.push_back(wb_val_o[p*DATA_W +: DATA_W]);
            model_commit(); @(negedge clk);
        end
        n_vec++;
        if (got.size() != 4) begin n_err++; $display("FAIL full_drain_count: got %0d expected 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            n_vec++;
            if (got[k] !== vals[k]) begin n_err++; $display("FAIL full_drain_v%0d: got %h expected %h", k, got[k], vals[k]); end
        end
    endtask

    task automatic test_flush();
        for (int j = 0; j < 4; j++) begin
            clr_in();
            if (j < 2) for (int c = 0; c < 3; c++) set_ch(c, 8*c + j, $urandom, 0, 0);
            if (j == 2) begin
                flush_i = 1'b1;
                for (int c = 0; c < NUM_CH; c++) set_ch(c, 30, $urandom, 0, 0);
            end
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL flush_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            if (j == 2) begin
                n_vec++;
                if (wb_valid_o !== 2'b00 || ch_ready_o !== 4'h0) begin
                    n_err++; $display("FAIL flush_pulse: got v=%b rdy=%h expected v=00 rdy=0", wb_valid_o, ch_ready_o);
                end
            end
            if (j == 3) begin
                n_vec++;
                if (wb_valid_o !== 2'b00 || ch_ready_o !== 4'hF) begin
                    n_err++; $display("FAIL flush_after: got v=%b rdy=%h expected v=00 rdy=f", wb_valid_o, ch_ready_o);
                end
            end
            model_commit(); @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        for (int j = 0; j < 2; j++) begin
            clr_in();
            for (int c = 0; c < NUM_CH; c++) set_ch(c, 4*c + j, $urandom, 0, 0);
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL areset_fill%0d: got %h expected %h", j, obs_vec, exp_vec); end
            model_commit(); @(negedge clk);
        end
        clr_in(); #1; model_eval();
        n_vec++;
        if (obs_vec !== exp_vec || wb_valid_o !== 2'b11) begin n_err++; $display("FAIL areset_pre: got %h expected %h", obs_vec, exp_vec); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb_valid_o !== 2'b00 || wb_idx_o !== '0 || wb_val_o !== '0) begin
            n_err++; $display("FAIL areset_immediate: got v=%b idx=%h val=%h expected all 0", wb_valid_o, wb_idx_o, wb_val_o);
        end
        model_reset();
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            clr_in();
            if (j == 2) rst_n = 1'b1;
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec || wb_valid_o !== 2'b00) begin n_err++; $display("FAIL areset_after%0d: got %h expected %h", j, obs_vec, exp_vec); end
            model_commit(); @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            clr_in();
            flush_i = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 99) < 60)
                    set_ch(c, $urandom_range(0, ROB_ENTRIES - 1), $urandom,
                           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            #1; model_eval();
            n_vec++;
            if (obs_vec !== exp_vec) begin n_err++; $display("FAIL random_cycle%0d: got %h expected %h", j, obs_vec, exp_vec); end
            model_commit(); @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_priority();
        test_full_fifo();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
